fetch_unit: RTL and testbench

Instruction fetch unit for the multicycle core: owns the architectural PC and issues one instruction-memory read at a time. It hands the fetched word to decode, then waits for execute to return the next PC. That next PC is the `next_pc`/`ialign` pair produced by the PC ALU, delivered here as `redirect_pc`/`ialign`. A misaligned target is turned into a held fetch fault instead of a memory access.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_unit.sv | 168 ++++++++++++++++
 tb/tb_fetch_unit.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
//
// Contents:
//   FETCH__INST_WIDTH - width of an instruction word
//   fetch_state_e     - fetch FSM states (REQ, WAIT, HOLD, EXEC, FAULT)
package fetch_pkg;

  localparam int FETCH__INST_WIDTH = 32;

  typedef enum logic [2:0] {
    REQ,
    WAIT,
    HOLD,
    EXEC,
    FAULT
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch unit for the multicycle core.
//
// Owns the architectural PC and keeps at most one instruction-memory read
// outstanding. The fetched word is presented to decode. The unit then waits
// for execute to return the next PC from the PC ALU. A misaligned next PC
// becomes a held fetch fault instead of a memory access.
//
// Parameters:
//   Width        - PC / address width (defaults to `ISA__XLEN)
//   ResetVector  - PC loaded on reset
//
// Ports:
//   clk_i            core clock
//   rst_i            synchronous active-high reset
//   redirect_i       execute finished; redirect_pc_i is valid
//   redirect_pc_i    next PC from the PC ALU
//   ialign_i         redirect_pc_i is not instruction-aligned
//   mem_req_valid_o  fetch request, held until accepted
//   mem_req_ready_i  memory accepts the request
//   mem_addr_o       fetch address (always the current PC)
//   mem_rsp_valid_i  read data valid (single-cycle pulse)
//   mem_rsp_data_i   instruction word from memory
//   inst_valid_o     instruction presented to decode
//   inst_ready_i     decode accepts the instruction
//   inst_o           instruction word
//   inst_pc_o        PC of inst_o
//   fault_o          instruction-address-misaligned fault pending
//   fault_addr_o     offending target address
//
// Build option:
//   FETCH__BYPASS_EN - when defined, a response is forwarded to decode in the
//                      same cycle it arrives; when undefined, inst_o and
//                      inst_valid_o come only from flops.

`ifndef ISA__XLEN
`define ISA__XLEN 32
`endif

module fetch_unit
  import fetch_pkg::*;
#(
  parameter int               Width       = `ISA__XLEN,
  parameter logic [Width-1:0] ResetVector = '0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         redirect_i,
  input  logic [Width-1:0]             redirect_pc_i,
  input  logic                         ialign_i,
  output logic                         mem_req_valid_o,
  input  logic                         mem_req_ready_i,
  output logic [Width-1:0]             mem_addr_o,
  input  logic                         mem_rsp_valid_i,
  input  logic [FETCH__INST_WIDTH-1:0] mem_rsp_data_i,
  output logic                         inst_valid_o,
  input  logic                         inst_ready_i,
  output logic [FETCH__INST_WIDTH-1:0] inst_o,
  output logic [Width-1:0]             inst_pc_o,
  output logic                         fault_o,
  output logic [Width-1:0]             fault_addr_o
);

  fetch_state_e                 state_q, state_d;
  logic [Width-1:0]             pc_q, pc_d;
  logic [FETCH__INST_WIDTH-1:0] inst_q, inst_d;
  logic [Width-1:0]             fault_addr_q, fault_addr_d;

  // State and datapath registers. Reset dominates every other event in the
  // same cycle; memory shares this reset so no stale response can follow.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= REQ;
      pc_q         <= ResetVector;
      inst_q       <= '0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  // Next-state logic. The PC only moves on an aligned redirect; a misaligned
  // one records the target in fault_addr and leaves the PC where it was.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    fault_addr_d = fault_addr_q;
    case (state_q)
      REQ: begin
        if (mem_req_ready_i) state_d = WAIT;
      end
      WAIT: begin
        if (mem_rsp_valid_i) begin
          inst_d  = mem_rsp_data_i;
`ifdef FETCH__BYPASS_EN
          state_d = inst_ready_i ? EXEC : HOLD;
`else
          state_d = HOLD;
`endif
        end
      end
      HOLD: begin
        if (inst_ready_i) state_d = EXEC;
      end
      EXEC, FAULT: begin
        if (redirect_i) begin
          if (ialign_i) begin
            fault_addr_d = redirect_pc_i;
            state_d      = FAULT;
          end else begin
            pc_d    = redirect_pc_i;
            state_d = REQ;
          end
        end
      end
      default: state_d = REQ;
    endcase
  end

  // Output decode. Decode-side outputs are forced to zero whenever no
  // instruction is being offered, so they read zero straight out of reset.
  always_comb begin
    mem_req_valid_o = 1'b0;
    inst_valid_o    = 1'b0;
    inst_o          = '0;
    inst_pc_o       = '0;
    case (state_q)
      REQ: mem_req_valid_o = 1'b1;
`ifdef FETCH__BYPASS_EN
      WAIT: begin
        if (mem_rsp_valid_i) begin
          inst_valid_o = 1'b1;
          inst_o       = mem_rsp_data_i;
          inst_pc_o    = pc_q;
        end
      end
`endif
      HOLD: begin
        inst_valid_o = 1'b1;
        inst_o       = inst_q;
        inst_pc_o    = pc_q;
      end
      default: ;
    endcase
  end

  assign mem_addr_o   = pc_q;
  assign fault_o      = (state_q == FAULT);
  assign fault_addr_o = fault_addr_q;

`ifndef SYNTHESIS
  // Protocol checks: a redirect only makes sense once the instruction has
  // been handed to execute, and a response only while a read is in flight.
  // Both events are ignored by the logic above; these just make them visible.
  always @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!redirect_i || state_q == EXEC || state_q == FAULT)
        else $warning("fetch_unit: redirect ignored outside EXEC/FAULT");
      assert (!mem_rsp_valid_i || state_q == WAIT)
        else $warning("fetch_unit: response ignored outside WAIT");
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with hand-computed expectations.
// Inputs are driven on the falling edge and outputs are checked on the
// falling edge, half a period away from the rising edge that updates state.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int               W  = 32;
  localparam logic [W-1:0]     RV = 32'h0000_0100;

  logic                         clk;
  logic                         rst;
  logic                         redirect;
  logic [W-1:0]                 redirectPc;
  logic                         ialign;
  logic                         memReqValid;
  logic                         memReqReady;
  logic [W-1:0]                 memAddr;
  logic                         memRspValid;
  logic [FETCH__INST_WIDTH-1:0] memRspData;
  logic                         instValid;
  logic                         instReady;
  logic [FETCH__INST_WIDTH-1:0] inst;
  logic [W-1:0]                 instPc;
  logic                         fault;
  logic [W-1:0]                 faultAddr;

  int compared   = 0;
  int mismatched = 0;

  fetch_unit #(.Width(W), .ResetVector(RV)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .redirect_i      (redirect),
    .redirect_pc_i   (redirectPc),
    .ialign_i        (ialign),
    .mem_req_valid_o (memReqValid),
    .mem_req_ready_i (memReqReady),
    .mem_addr_o      (memAddr),
    .mem_rsp_valid_i (memRspValid),
    .mem_rsp_data_i  (memRspData),
    .inst_valid_o    (instValid),
    .inst_ready_i    (instReady),
    .inst_o          (inst),
    .inst_pc_o       (instPc),
    .fault_o         (fault),
    .fault_addr_o    (faultAddr)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something upstream stalls the sequence
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(negedge clk);
  endtask

  // Reset held two cycles, released; REQ at the reset vector, all else zero
  task automatic test_reset();
    rst = 1'b1; redirect = 1'b0; redirectPc = '0; ialign = 1'b0;
    memReqReady = 1'b0; memRspValid = 1'b0; memRspData = '0; instReady = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    step();
    compared++;
    if (memReqValid !== 1'b1 || memAddr !== RV) begin
      mismatched++;
      $display("[TB] FAIL reset_req: actual valid=%b addr=%h required valid=1 addr=%h", memReqValid, memAddr, RV);
    end
    compared++;
    if (instValid !== 1'b0 || inst !== '0 || instPc !== '0 || fault !== 1'b0 || faultAddr !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_outs: actual iv=%b inst=%h ipc=%h f=%b fa=%h required all 0", instValid, inst, instPc, fault, faultAddr);
    end
  endtask

  // Memory not ready for three cycles; request and address must hold
  task automatic test_req_stall();
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      compared++;
      if (memReqValid !== 1'b1 || memAddr !== 32'h100) begin
        mismatched++;
        $display("[TB] FAIL req_stall%0d: actual valid=%b addr=%h required valid=1 addr=100", i, memReqValid, memAddr);
      end
    end
    memReqReady = 1'b1;
  endtask

  // First response 0x13 at PC 0x100
  task automatic test_response();
    step();
    memReqReady = 1'b0;
    compared++;
    if (memReqValid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL wait_no_req: actual valid=%b required 0", memReqValid);
    end
    memRspValid = 1'b1;
    memRspData  = 32'h0000_0013;
`ifdef FETCH__BYPASS_EN
    #1;
    compared++;
    if (instValid !== 1'b1 || inst !== 32'h13 || instPc !== 32'h100) begin
      mismatched++;
      $display("[TB] FAIL bypass_inst: actual iv=%b inst=%h ipc=%h required iv=1 inst=13 ipc=100", instValid, inst, instPc);
    end
`else
    compared++;
    if (instValid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL wait_no_inst: actual iv=%b required 0", instValid);
    end
`endif
  endtask

  // Decode stalls two cycles; a redirect during HOLD must be ignored
  task automatic test_hold_and_ignore();
    step();
    memRspValid = 1'b0;
    memRspData  = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      if (i > 0) step();
      compared++;
      if (instValid !== 1'b1 || inst !== 32'h13 || instPc !== 32'h100) begin
        mismatched++;
        $display("[TB] FAIL hold%0d: actual iv=%b inst=%h ipc=%h required iv=1 inst=13 ipc=100", i, instValid, inst, instPc);
      end
    end
    redirect = 1'b1; redirectPc = 32'h300; ialign = 1'b0;
    step();
    redirect = 1'b0;
    compared++;
    if (instValid !== 1'b1 || instPc !== 32'h100 || memAddr !== 32'h100 || memReqValid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL hold_redirect_ignored: actual iv=%b ipc=%h addr=%h req=%b required iv=1 ipc=100 addr=100 req=0", instValid, instPc, memAddr, memReqValid);
    end
    instReady = 1'b1;
  endtask

  // EXEC, aligned redirect to 0x104, second fetch
  task automatic test_redirect();
    step();
    instReady = 1'b0;
    compared++;
    if (instValid !== 1'b0 || memReqValid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL exec_idle: actual iv=%b req=%b required 0 0", instValid, memReqValid);
    end
    redirect = 1'b1; redirectPc = 32'h104; ialign = 1'b0;
    step();
    redirect = 1'b0;
    compared++;
    if (memReqValid !== 1'b1 || memAddr !== 32'h104) begin
      mismatched++;
      $display("[TB] FAIL redirect_req: actual valid=%b addr=%h required valid=1 addr=104", memReqValid, memAddr);
    end
    memReqReady = 1'b1;
    step();
    memReqReady = 1'b0;
    memRspValid = 1'b1; memRspData = 32'h0050_0093;
    step();
    memRspValid = 1'b0; memRspData = '0;
    compared++;
    if (instValid !== 1'b1 || inst !== 32'h0050_0093 || instPc !== 32'h104) begin
      mismatched++;
      $display("[TB] FAIL second_inst: actual iv=%b inst=%h ipc=%h required iv=1 inst=00500093 ipc=104", instValid, inst, instPc);
    end
    instReady = 1'b1;
  endtask

  // Misaligned redirect, a second misaligned one, then the trap vector
  task automatic test_fault();
    step();
    instReady = 1'b0;
    redirect = 1'b1; redirectPc = 32'h102; ialign = 1'b1;
    step();
    redirect = 1'b0; ialign = 1'b0;
    compared++;
    if (fault !== 1'b1 || faultAddr !== 32'h102 || memReqValid !== 1'b0 || memAddr !== 32'h104) begin
      mismatched++;
      $display("[TB] FAIL fault_entry: actual f=%b fa=%h req=%b addr=%h required f=1 fa=102 req=0 addr=104", fault, faultAddr, memReqValid, memAddr);
    end
    redirect = 1'b1; redirectPc = 32'h106; ialign = 1'b1;
    step();
    redirect = 1'b0; ialign = 1'b0;
    compared++;
    if (fault !== 1'b1 || faultAddr !== 32'h106 || memReqValid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL fault_update: actual f=%b fa=%h req=%b required f=1 fa=106 req=0", fault, faultAddr, memReqValid);
    end
    redirect = 1'b1; redirectPc = 32'h200; ialign = 1'b0;
    step();
    redirect = 1'b0;
    compared++;
    if (fault !== 1'b0 || memReqValid !== 1'b1 || memAddr !== 32'h200) begin
      mismatched++;
      $display("[TB] FAIL trap_vector: actual f=%b req=%b addr=%h required f=0 req=1 addr=200", fault, memReqValid, memAddr);
    end
  endtask

  // Reset taken in WAIT (with a colliding response) and in HOLD
  task automatic test_reset_midflight();
    memReqReady = 1'b1;
    step();
    memReqReady = 1'b0;
    rst = 1'b1; memRspValid = 1'b1; memRspData = 32'hAAAA_5555;
    step();
    rst = 1'b0; memRspValid = 1'b0;
    compared++;
    if (memReqValid !== 1'b1 || memAddr !== RV || instValid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_in_wait: actual req=%b addr=%h iv=%b required req=1 addr=100 iv=0", memReqValid, memAddr, instValid);
    end
    memReqReady = 1'b1;
    step();
    memReqReady = 1'b0;
    memRspValid = 1'b1; memRspData = 32'hDEAD_BEEF;
    step();
    memRspValid = 1'b0;
    compared++;
    if (instValid !== 1'b1 || inst !== 32'hDEAD_BEEF || instPc !== RV) begin
      mismatched++;
      $display("[TB] FAIL pre_reset_hold: actual iv=%b inst=%h ipc=%h required iv=1 inst=deadbeef ipc=100", instValid, inst, instPc);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    compared++;
    if (instValid !== 1'b0 || inst !== '0 || memReqValid !== 1'b1 || memAddr !== RV) begin
      mismatched++;
      $display("[TB] FAIL reset_in_hold: actual iv=%b inst=%h req=%b addr=%h required iv=0 inst=0 req=1 addr=100", instValid, inst, memReqValid, memAddr);
    end
  endtask

  // Scenario sequence
  initial begin
    $display("[TB] starting fetch_unit directed test");
    test_reset();
    test_req_stall();
    test_response();
    test_hold_and_ignore();
    test_redirect();
    test_fault();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
